// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared widths and defaults for the key conditioner and rpncalc
package rpn_pkg;

  localparam int NUM_KEYS            = 4;
  localparam int VAL_W               = 16;
  localparam int MODE_W              = 2;
  localparam int SW_W                = VAL_W + MODE_W;
  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int CNT_W_DEF           = 18;

  // Isolate the lowest set bit; zero in gives zero out.
  function automatic logic [NUM_KEYS-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    return v & (~v + NUM_KEYS'(1));
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - board inputs and conditioned key/operand outputs
interface key_conditioner_if;
  import rpn_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic [SW_W-1:0]     sw_raw;
  logic [NUM_KEYS-1:0] key;
  logic [VAL_W-1:0]    val;
  logic [MODE_W-1:0]   mode;

  modport master (
    input  key_raw,
    input  sw_raw,
    output key,
    output val,
    output mode
  );

  modport slave (
    output key_raw,
    output sw_raw,
    input  key,
    input  val,
    input  mode
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one pushbutton: synchronizer, debounce counter, press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = rpn_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = rpn_pkg::CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  // Counter value on which a still-differing input is accepted.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             bit_s;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  assign bit_s = sync[1];

  // Two-flop synchronizer; idles released (high) so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Count consecutive differing cycles; flip stable after DEBOUNCE_CYCLES of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (bit_s == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= bit_s;
        cnt    <= '0;
        // Only the falling (press) direction raises an event.
        press  <= ~bit_s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced pushbuttons to one-cycle rpncalc key strobes
module key_conditioner
  import rpn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  key_conditioner_if.master  bus
);

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] grant;
  logic [SW_W-1:0]     sw_meta;
  logic [SW_W-1:0]     sw_sync;
  logic [NUM_KEYS-1:0] key_q;
  logic [VAL_W-1:0]    val_q;
  logic [MODE_W-1:0]   mode_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.key_raw[i]),
      .press (press[i])
    );
  end

  // Two-flop synchronizer for the operand/mode switches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.sw_raw;
      sw_sync <= sw_meta;
    end
  end

  // Lowest index wins, so simultaneous presses drain in ascending order.
  assign grant = lowest_set(pending);

  // Pending presses: new events OR in (repeat presses coalesce), granted bit retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant) | press;
    end
  end

  // Emit one active-low strobe per cycle and latch the switches alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q  <= '1;
      val_q  <= '0;
      mode_q <= '0;
    end else if (|pending) begin
      key_q  <= ~grant;
      val_q  <= sw_sync[VAL_W-1:0];
      mode_q <= sw_sync[SW_W-1:VAL_W];
    end else begin
      key_q  <= '1;
    end
  end

  assign bus.key  = key_q;
  assign bus.val  = val_q;
  assign bus.mode = mode_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  key_conditioner_if bus ();

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // n edges after the current drive point; index i is the i-th rising edge.
  task automatic window(input string tag, input int n, input int e1, input logic [3:0] k1,
                        input int e2, input logic [3:0] k2);
    logic [3:0] want;
    for (int i = 0; i < n; i++) begin
      tick();
      want = 4'hF;
      if (i == e1) want = k1;
      if (i == e2) want = k2;
      chk($sformatf("%s_e%0d", tag, i), {28'd0, bus.key}, {28'd0, want});
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.key_raw = 4'h0;
    bus.sw_raw  = 18'h3FFFF;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_key",  {28'd0, bus.key},  32'hF);
      chk("reset_val",  {16'd0, bus.val},  32'h0);
      chk("reset_mode", {30'd0, bus.mode}, 32'h0);
    end
    bus.key_raw = 4'hF;
    bus.sw_raw  = 18'h20003;
    tick();
    tick();
    rst = 1'b1;
    window("idle", 8, -1, 4'hF, -1, 4'hF);
    chk("idle_val", {16'd0, bus.val}, 32'h0);

    bus.key_raw = 4'hE;
    window("clean", 20, 7, 4'hE, -1, 4'hF);
    chk("clean_val",  {16'd0, bus.val},  32'h0003);
    chk("clean_mode", {30'd0, bus.mode}, 32'h2);
    bus.sw_raw  = 18'h1ABCD;
    bus.key_raw = 4'hF;
    window("clean_rel", 10, -1, 4'hF, -1, 4'hF);
    chk("hold_val",  {16'd0, bus.val},  32'h0003);
    chk("hold_mode", {30'd0, bus.mode}, 32'h2);

    bus.key_raw = 4'hD;
    window("bounce_l0", 2, -1, 4'hF, -1, 4'hF);
    bus.key_raw = 4'hF;
    window("bounce_h0", 2, -1, 4'hF, -1, 4'hF);
    bus.key_raw = 4'hD;
    window("bounce_l1", 2, -1, 4'hF, -1, 4'hF);
    bus.key_raw = 4'hF;
    window("bounce_h1", 2, -1, 4'hF, -1, 4'hF);
    bus.key_raw = 4'hD;
    window("bounce", 20, 7, 4'hD, -1, 4'hF);
    bus.key_raw = 4'hF;
    window("bounce_rel", 10, -1, 4'hF, -1, 4'hF);

    bus.key_raw = 4'h6;
    window("simul", 20, 7, 4'hE, 8, 4'h7);
    chk("simul_val",  {16'd0, bus.val},  32'hABCD);
    chk("simul_mode", {30'd0, bus.mode}, 32'h1);
    bus.key_raw = 4'hF;
    window("simul_rel", 10, -1, 4'hF, -1, 4'hF);

    bus.key_raw = 4'hB;
    window("glitch", 3, -1, 4'hF, -1, 4'hF);
    bus.key_raw = 4'hF;
    window("glitch_gap", 10, -1, 4'hF, -1, 4'hF);
    bus.key_raw = 4'hB;
    window("long", 20, 7, 4'hB, -1, 4'hF);
    bus.key_raw = 4'hF;
    window("long_rel", 15, -1, 4'hF, -1, 4'hF);

    bus.key_raw = 4'h7;
    window("mid_pre", 4, -1, 4'hF, -1, 4'hF);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_key", {28'd0, bus.key},  32'hF);
      chk("mid_rst_val", {16'd0, bus.val},  32'h0);
    end
    rst = 1'b1;
    window("mid_post", 20, 7, 4'h7, -1, 4'hF);
    chk("mid_val",  {16'd0, bus.val},  32'hABCD);
    chk("mid_mode", {30'd0, bus.mode}, 32'h1);
    bus.key_raw = 4'hF;
    window("mid_rel", 10, -1, 4'hF, -1, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
